// File: rtl/branch_predict_resolve_unit.sv
// rtl/branch_predict_resolve_unit.sv - EX branch resolve with 2-bit BHT predictor and branch/miss statistics
module branch_predict_resolve_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int PC_WIDTH    = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [PC_WIDTH-1:0]   FETCH_PC,
    output logic                  PREDICT_TAKEN,
    input  logic                  EX_VALID,
    input  logic                  STALL,
    input  logic [PC_WIDTH-1:0]   EX_PC,
    input  logic                  EX_PREDICTED,
    input  logic [DATA_WIDTH-1:0] DATA1,
    input  logic [DATA_WIDTH-1:0] DATA2,
    input  logic [3:0]            SELECT,
    input  logic                  CLR_STATS,
    output logic                  PC_MUX_OUT,
    output logic                  MISPREDICT,
    output logic [CNT_WIDTH-1:0]  BRANCH_COUNT,
    output logic [CNT_WIDTH-1:0]  MISS_COUNT
);

    localparam int IDX = $clog2(BHT_ENTRIES);

    logic [1:0]     bht [BHT_ENTRIES];
    logic [IDX-1:0] lookup_idx;
    logic [IDX-1:0] update_idx;
    logic           taken;
    logic           active;
    logic           mismatch;
    logic           train;
    logic           unused_pc_bits;

    // Word-aligned PCs: bits [1:0] never select an entry, upper bits alias.
    assign lookup_idx     = FETCH_PC[IDX+1:2];
    assign update_idx     = EX_PC[IDX+1:2];
    assign unused_pc_bits = ^{FETCH_PC[PC_WIDTH-1:IDX+2], FETCH_PC[1:0],
                              EX_PC[PC_WIDTH-1:IDX+2], EX_PC[1:0]};

    // Prediction reads the table before any same-cycle training write lands.
    assign PREDICT_TAKEN = bht[lookup_idx][1];

    // Direction resolve; code 011 is reserved and never counts as a branch.
    always_comb begin
        taken = 1'b0;
        if (SELECT[3]) begin
            case (SELECT[2:0])
                3'b000:  taken = (DATA1 == DATA2);
                3'b001:  taken = (DATA1 != DATA2);
                3'b010:  taken = 1'b1;
                3'b100:  taken = ($signed(DATA1) <  $signed(DATA2));
                3'b101:  taken = ($signed(DATA1) >= $signed(DATA2));
                3'b110:  taken = (DATA1 <  DATA2);
                3'b111:  taken = (DATA1 >= DATA2);
                default: taken = 1'b0;
            endcase
        end
    end

    assign active   = EX_VALID & ~STALL & SELECT[3] & (SELECT[2:0] != 3'b011);
    assign mismatch = active & (taken != EX_PREDICTED);
    assign train    = active & (SELECT[2:0] != 3'b010);

    // Registered resolve outputs; frozen while the pipeline stalls.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            PC_MUX_OUT <= 1'b0;
            MISPREDICT <= 1'b0;
        end else if (!STALL) begin
            PC_MUX_OUT <= active & taken;
            MISPREDICT <= mismatch;
        end
    end

    // Saturating 2-bit counters trained only by conditional branches.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (train) begin
            if (taken && bht[update_idx] != 2'b11) begin
                bht[update_idx] <= bht[update_idx] + 2'd1;
            end else if (!taken && bht[update_idx] != 2'b00) begin
                bht[update_idx] <= bht[update_idx] - 2'd1;
            end
        end
    end

    // Statistics counters saturate at all-ones; clear wins over any increment.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            BRANCH_COUNT <= '0;
            MISS_COUNT   <= '0;
        end else if (CLR_STATS) begin
            BRANCH_COUNT <= '0;
            MISS_COUNT   <= '0;
        end else begin
            if (active && !(&BRANCH_COUNT)) begin
                BRANCH_COUNT <= BRANCH_COUNT + CNT_WIDTH'(1);
            end
            if (mismatch && !(&MISS_COUNT)) begin
                MISS_COUNT <= MISS_COUNT + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_resolve_unit.sv
// tb/tb_branch_predict_resolve_unit.sv - self-checking bench for branch_predict_resolve_unit
module tb_branch_predict_resolve_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] FETCH_PC;
    logic        EX_VALID;
    logic        STALL;
    logic [31:0] EX_PC;
    logic        EX_PREDICTED;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic [3:0]  SELECT;
    logic        CLR_STATS;

    logic        pt_a, pcm_a, mis_a;
    logic [15:0] bc_a, mc_a;
    logic        pt_b, pcm_b, mis_b;
    logic [3:0]  bc_b, mc_b;

    int checks = 0;
    int errors = 0;

    int m_bht [16];
    int m_pcmux, m_mis, m_bc, m_mc, m_bc4, m_mc4;

    always #5 CLK = ~CLK;

    branch_predict_resolve_unit u_dut (
        .CLK(CLK), .RESET(RESET), .FETCH_PC(FETCH_PC), .PREDICT_TAKEN(pt_a),
        .EX_VALID(EX_VALID), .STALL(STALL), .EX_PC(EX_PC), .EX_PREDICTED(EX_PREDICTED),
        .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT), .CLR_STATS(CLR_STATS),
        .PC_MUX_OUT(pcm_a), .MISPREDICT(mis_a), .BRANCH_COUNT(bc_a), .MISS_COUNT(mc_a)
    );

    branch_predict_resolve_unit #(.CNT_WIDTH(4)) u_sat (
        .CLK(CLK), .RESET(RESET), .FETCH_PC(FETCH_PC), .PREDICT_TAKEN(pt_b),
        .EX_VALID(EX_VALID), .STALL(STALL), .EX_PC(EX_PC), .EX_PREDICTED(EX_PREDICTED),
        .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT), .CLR_STATS(CLR_STATS),
        .PC_MUX_OUT(pcm_b), .MISPREDICT(mis_b), .BRANCH_COUNT(bc_b), .MISS_COUNT(mc_b)
    );

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        exp_taken;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit ref_taken(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        if (!sel[3]) return 1'b0;
        case (sel[2:0])
            3'd0: return a == b;
            3'd1: return a != b;
            3'd2: return 1'b1;
            3'd3: return 1'b0;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            default: return a >= b;
        endcase
    endfunction

    function automatic bit ref_predict(input logic [31:0] pc);
        return m_bht[(pc >> 2) % 16] >= 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_pcmux = 0; m_mis = 0; m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
    endtask

    task automatic model_edge();
        bit act, t, mm;
        int idx;
        t   = ref_taken(SELECT, DATA1, DATA2);
        act = EX_VALID && !STALL && SELECT[3] && SELECT[2:0] != 3'd3;
        mm  = act && (t != EX_PREDICTED);
        if (!STALL) begin
            m_pcmux = act && t;
            m_mis   = mm;
        end
        if (act && SELECT[2:0] != 3'd2) begin
            idx = (EX_PC >> 2) % 16;
            if (t) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
            else   m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
        end
        if (CLR_STATS) begin
            m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
        end else begin
            if (act) begin
                m_bc  = (m_bc  < 65535) ? m_bc  + 1 : m_bc;
                m_bc4 = (m_bc4 < 15)    ? m_bc4 + 1 : m_bc4;
            end
            if (mm) begin
                m_mc  = (m_mc  < 65535) ? m_mc  + 1 : m_mc;
                m_mc4 = (m_mc4 < 15)    ? m_mc4 + 1 : m_mc4;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc_mux"},  32'(pcm_a), 32'(m_pcmux));
        check({tag, ".mispred"}, 32'(mis_a), 32'(m_mis));
        check({tag, ".br_cnt"},  32'(bc_a),  32'(m_bc));
        check({tag, ".miss_cnt"}, 32'(mc_a), 32'(m_mc));
        check({tag, ".br_cnt4"}, 32'(bc_b),  32'(m_bc4));
        check({tag, ".miss_cnt4"}, 32'(mc_b), 32'(m_mc4));
        check({tag, ".predict"}, 32'(pt_a),  32'(ref_predict(FETCH_PC)));
        check({tag, ".predict4"}, 32'(pt_b), 32'(ref_predict(FETCH_PC)));
    endtask

    // One clock: drive inputs, check lookup before the edge, then outputs after it.
    task automatic step(input logic v, input logic st, input logic [31:0] pc, input logic pred,
                        input logic [3:0] sel, input logic [31:0] d1, input logic [31:0] d2,
                        input logic clr, input logic [31:0] fpc, input string tag);
        EX_VALID = v; STALL = st; EX_PC = pc; EX_PREDICTED = pred;
        SELECT = sel; DATA1 = d1; DATA2 = d2; CLR_STATS = clr; FETCH_PC = fpc;
        #1;
        check({tag, ".pre_predict"}, 32'(pt_a), 32'(ref_predict(fpc)));
        @(posedge CLK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        vecs[0]  = '{4'b1100, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b1};
        vecs[1]  = '{4'b1110, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0};
        vecs[2]  = '{4'b1000, 32'd5, 32'd5, 1'b1, 1'b1};
        vecs[3]  = '{4'b1111, 32'd0, 32'd0, 1'b1, 1'b1};
        vecs[4]  = '{4'b1001, 32'd5, 32'd5, 1'b0, 1'b0};
        vecs[5]  = '{4'b1101, 32'd1, 32'hFFFFFFFF, 1'b1, 1'b1};
        vecs[6]  = '{4'b1010, 32'd3, 32'd9, 1'b1, 1'b1};
        vecs[7]  = '{4'b1011, 32'd5, 32'd5, 1'b0, 1'b0};
        vecs[8]  = '{4'b0000, 32'd5, 32'd5, 1'b0, 1'b0};
        vecs[9]  = '{4'b1100, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[10] = '{4'b1111, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[11] = '{4'b1110, 32'd1, 32'd2, 1'b1, 1'b1};

        RESET = 1'b0; EX_VALID = 0; STALL = 0; EX_PC = 0; EX_PREDICTED = 0;
        SELECT = 0; DATA1 = 0; DATA2 = 0; CLR_STATS = 0; FETCH_PC = 32'h44;
        model_reset();
        #12;
        RESET = 1'b1;
        #1;
        check("rst.predict", 32'(pt_a), 32'd0);
        check("rst.pc_mux", 32'(pcm_a), 32'd0);
        check("rst.mispred", 32'(mis_a), 32'd0);
        check("rst.br_cnt", 32'(bc_a), 32'd0);
        check("rst.miss_cnt", 32'(mc_a), 32'd0);

        for (int i = 0; i < 12; i++) begin
            step(1, 0, 32'(i * 4 + 4), 0, vecs[i].sel, vecs[i].d1, vecs[i].d2, 0, 32'h100, $sformatf("vec%0d", i));
            check($sformatf("vec%0d.taken", i), 32'(pcm_a), 32'(vecs[i].exp_taken));
            check($sformatf("vec%0d.mis", i), 32'(mis_a), 32'(vecs[i].exp_mis));
        end

        // Asynchronous reset between edges
        step(1, 0, 32'h8, 0, 4'b1000, 32'd5, 32'd5, 0, 32'h0, "pre_async");
        RESET = 1'b0;
        #2;
        check("async.pc_mux", 32'(pcm_a), 32'd0);
        check("async.mispred", 32'(mis_a), 32'd0);
        check("async.br_cnt", 32'(bc_a), 32'd0);
        model_reset();
        #2;
        RESET = 1'b1;

        // Training at 0x40: four taken BEQs mispredicted, then two not-taken
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 32'h40, 0, 4'b1000, 32'd7, 32'd7, 0, 32'h40, $sformatf("train%0d", i));
            check($sformatf("train%0d.predict", i), 32'(pt_a), 32'd1);
            check($sformatf("train%0d.mis", i), 32'(mis_a), 32'd1);
        end
        check("train.br_cnt", 32'(bc_a), 32'd4);
        check("train.miss_cnt", 32'(mc_a), 32'd4);
        step(1, 0, 32'h40, 0, 4'b1000, 32'd7, 32'd8, 0, 32'h40, "untrain0");
        check("untrain0.predict", 32'(pt_a), 32'd1);
        step(1, 0, 32'h40, 0, 4'b1000, 32'd7, 32'd8, 0, 32'h40, "untrain1");
        check("untrain1.predict", 32'(pt_a), 32'd0);

        // Jump trains nothing but can mispredict; non-branch codes are ignored
        step(1, 0, 32'h40, 0, 4'b1010, 32'd0, 32'd0, 0, 32'h40, "jal");
        check("jal.mis", 32'(mis_a), 32'd1);
        check("jal.predict", 32'(pt_a), 32'd0);
        check("jal.br_cnt", 32'(bc_a), 32'd7);
        step(1, 0, 32'h40, 0, 4'b0000, 32'd5, 32'd5, 0, 32'h40, "nonbr0");
        step(1, 0, 32'h40, 0, 4'b1011, 32'd5, 32'd5, 0, 32'h40, "nonbr1");
        check("nonbr.pc_mux", 32'(pcm_a), 32'd0);
        check("nonbr.br_cnt", 32'(bc_a), 32'd7);
        check("nonbr.miss_cnt", 32'(mc_a), 32'd5);

        // Stall holds everything
        step(1, 0, 32'h40, 0, 4'b1010, 32'd0, 32'd0, 0, 32'h40, "jal2");
        step(1, 1, 32'h40, 1, 4'b1000, 32'd1, 32'd2, 0, 32'h40, "stall");
        check("stall.pc_mux", 32'(pcm_a), 32'd1);
        check("stall.mis", 32'(mis_a), 32'd1);
        check("stall.br_cnt", 32'(bc_a), 32'd8);
        check("stall.miss_cnt", 32'(mc_a), 32'd6);
        check("stall.predict", 32'(pt_a), 32'd0);

        // Clear beats a same-cycle mispredict
        step(1, 0, 32'h40, 0, 4'b1010, 32'd0, 32'd0, 1, 32'h40, "clr");
        check("clr.br_cnt", 32'(bc_a), 32'd0);
        check("clr.miss_cnt", 32'(mc_a), 32'd0);
        check("clr.mis", 32'(mis_a), 32'd1);

        // Saturation of the narrow counters
        for (int i = 0; i < 20; i++)
            step(1, 0, 32'h80, 1, 4'b1000, 32'd3, 32'd3, 0, 32'h80, $sformatf("sat%0d", i));
        check("sat.br_cnt4", 32'(bc_b), 32'd15);
        check("sat.br_cnt", 32'(bc_a), 32'd20);
        check("sat.miss_cnt", 32'(mc_a), 32'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b;
            a = ($urandom % 4 == 0) ? $urandom : 32'($urandom % 4);
            b = ($urandom % 3 == 0) ? a : (($urandom % 4 == 0) ? $urandom : 32'($urandom % 4));
            step(($urandom % 4) != 0, ($urandom % 6) == 0, 32'(($urandom % 24) * 4),
                 1'($urandom % 2), 4'($urandom % 16), a, b, ($urandom % 40) == 0,
                 32'(($urandom % 24) * 4), $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
